matrix_scan_controller: RTL and testbench

Generates the column-scan timing and holds the displayed image for the 5x7 LED matrix. Sits directly upstream of the matrix display driver: supplies its one-hot `ring_counter[2:0]` and the three column-group row patterns `col_2`, `col_1` and `col_0`. Double-buffers the image so that producers can load a new frame at any time without tearing. The new frame is swapped in only at a frame boundary.

---
 rtl/matrix_scan_controller_pkg.sv | 14 +
 rtl/matrix_scan_controller_if.sv | 15 +
 rtl/matrix_scan_controller_prescaler.sv | 26 ++
 rtl/matrix_scan_controller.sv | 108 ++++++++++
 tb/tb_matrix_scan_controller.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_scan_controller_pkg.sv
// Shared types and constants for the 5x7 matrix scan controller.
package matrix_pkg;
  localparam int NUM_GROUPS = 3;
  localparam int NUM_ROWS   = 7;

  typedef logic [NUM_ROWS-1:0] column_t;
  typedef logic [2:0]          ring_t;

  localparam ring_t RING_RESET = 3'b001;

  function automatic ring_t ring_rotate(input ring_t r);
    return {r[1:0], r[2]};
  endfunction
endpackage

// File: rtl/matrix_scan_controller_if.sv
// Frame-load handshake between an image producer and the scan controller.
interface matrix_scan_controller_if;
  import matrix_pkg::*;

  logic    img_valid;
  logic    img_ready;
  column_t img_col_2;
  column_t img_col_1;
  column_t img_col_0;

  modport master (output img_valid, output img_col_2, output img_col_1, output img_col_0,
                  input img_ready);
  modport slave  (input img_valid, input img_col_2, input img_col_1, input img_col_0,
                  output img_ready);
endinterface

// File: rtl/matrix_scan_controller_prescaler.sv
// Column-slot prescaler: counts 0..DIVIDER-1 while enabled, ticks on the last count.
module matrix_prescaler #(
  parameter int  DIVIDER = 50000,
  localparam int CNT_W   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             tick
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDER - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end
  end

  assign count = count_reg;
  assign tick  = enable && (count_reg == LAST);
endmodule

// File: rtl/matrix_scan_controller.sv
// Column-scan timing and double-buffered image for a 5x7 LED matrix.
// Define MATRIX_SCAN_BLANK_EN to blank ring_counter for BLANK_CYCLES at each slot start.
module matrix_scan_controller
  import matrix_pkg::*;
#(
  parameter int DIVIDER      = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      scan_en,
  matrix_scan_controller_if.slave   img,
  output ring_t                     ring_counter,
  output column_t                   col_2,
  output column_t                   col_1,
  output column_t                   col_0,
  output logic                      frame_start
);
  localparam int CNT_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

  logic [CNT_W-1:0] slot_cnt;
  logic             tick;

  matrix_prescaler #(.DIVIDER(DIVIDER)) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (scan_en),
    .count  (slot_cnt),
    .tick   (tick)
  );

  ring_t   ring_reg;
  logic    pending_reg;
  logic    frame_start_reg;
  logic    boundary;
  logic    transfer;
  logic    swap;
  column_t img_cols    [NUM_GROUPS];
  column_t active_cols [NUM_GROUPS];

  assign img_cols[0] = img.img_col_0;
  assign img_cols[1] = img.img_col_1;
  assign img_cols[2] = img.img_col_2;

  assign boundary = tick && (ring_reg == 3'b100);
  assign transfer = img.img_valid && !pending_reg;
  // A transfer landing on a boundary cannot swap: pending was still clear.
  assign swap     = boundary && pending_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      ring_reg        <= RING_RESET;
      pending_reg     <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= boundary;
      if (tick) begin
        ring_reg <= ring_rotate(ring_reg);
      end
      if (transfer) begin
        pending_reg <= 1'b1;
      end else if (swap) begin
        pending_reg <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GROUPS; gi++) begin : g_group
      column_t shadow_reg;
      column_t active_reg;

      always_ff @(posedge clock) begin
        if (reset) begin
          shadow_reg <= '0;
          active_reg <= '0;
        end else begin
          if (transfer) begin
            shadow_reg <= img_cols[gi];
          end
          if (swap) begin
            active_reg <= shadow_reg;
          end
        end
      end

      assign active_cols[gi] = active_reg;
    end
  endgenerate

`ifdef MATRIX_SCAN_BLANK_EN
  logic blank;
  assign blank        = slot_cnt < CNT_W'(BLANK_CYCLES);
  assign ring_counter = (scan_en && !blank) ? ring_reg : '0;
`else
  logic            unused_slot_cnt;
  localparam int   unused_blank_cycles = BLANK_CYCLES;
  assign unused_slot_cnt = ^slot_cnt;
  assign ring_counter    = scan_en ? ring_reg : '0;
`endif

  assign img.img_ready = !pending_reg;
  assign col_0         = active_cols[0];
  assign col_1         = active_cols[1];
  assign col_2         = active_cols[2];
  assign frame_start   = frame_start_reg;
endmodule

// File: tb/tb_matrix_scan_controller.sv
// Self-checking bench for matrix_scan_controller: vector table, corner sequences, random vs model.
module tb_matrix_scan_controller;
  import matrix_pkg::*;

  localparam int D     = 4;
  localparam int BLANK = 1;
`ifdef MATRIX_SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic    clk;
  logic    rst;
  logic    en;
  ring_t   ring_counter;
  column_t col_2, col_1, col_0;
  logic    frame_start;

  matrix_scan_controller_if img_if ();

  matrix_scan_controller #(.DIVIDER(D), .BLANK_CYCLES(BLANK)) dut (
    .clock        (clk),
    .reset        (rst),
    .scan_en      (en),
    .img          (img_if),
    .ring_counter (ring_counter),
    .col_2        (col_2),
    .col_1        (col_1),
    .col_0        (col_0),
    .frame_start  (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ring_t gate(input ring_t r, input int cnt, input logic e);
    if (!e) return 3'b000;
    if (BLANK_ON && cnt < BLANK) return 3'b000;
    return r;
  endfunction

  // Reference model: position within the frame counted in enabled cycles, frames in a queue.
  int             en_pos;
  column_t        m_act [3];
  logic [20:0]    m_q [$];
  logic           m_fs;

  task automatic model_update();
    logic        boundary;
    logic        xfer;
    logic [20:0] f;
    if (rst) begin
      en_pos = 0;
      m_q.delete();
      m_act  = '{default: '0};
      m_fs   = 1'b0;
    end else begin
      boundary = en && (en_pos == 3*D - 1);
      xfer     = img_if.img_valid && (m_q.size() == 0);
      m_fs     = boundary;
      if (boundary && m_q.size() > 0) begin
        f        = m_q.pop_front();
        m_act[2] = f[20:14];
        m_act[1] = f[13:7];
        m_act[0] = f[6:0];
      end
      if (xfer) m_q.push_back({img_if.img_col_2, img_if.img_col_1, img_if.img_col_0});
      if (en) en_pos = (en_pos + 1) % (3*D);
    end
  endtask

  function automatic ring_t model_ring();
    return gate(ring_t'(3'b001 << (en_pos / D)), en_pos % D, en);
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic e, input logic v, input column_t c2, c1, c0);
    en               = e;
    img_if.img_valid = v;
    img_if.img_col_2 = c2;
    img_if.img_col_1 = c1;
    img_if.img_col_0 = c0;
  endtask

  typedef struct {
    logic    en;
    logic    valid;
    column_t c2, c1, c0;
    ring_t   ring;
    int      cnt;
    logic    ready;
    column_t e2, e1, e0;
    logic    fs;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input logic v, input column_t c2, c1, c0, input ring_t r, input int cnt,
                     input logic rdy, input column_t e2, e1, e0, input logic fs);
    vec_t x;
    x.en = 1'b1; x.valid = v; x.c2 = c2; x.c1 = c1; x.c0 = c0;
    x.ring = r; x.cnt = cnt; x.ready = rdy; x.e2 = e2; x.e1 = e1; x.e0 = e0; x.fs = fs;
    vecs.push_back(x);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 7'h00, 7'h00, 7'h00);
    // Load A in slot 010, offer B while pending, B accepted right after the swap.
    add(0, 7'h00, 7'h00, 7'h00, 3'b001, 1, 1, 7'h00, 7'h00, 7'h00, 0);
    add(0, 7'h00, 7'h00, 7'h00, 3'b001, 2, 1, 7'h00, 7'h00, 7'h00, 0);
    add(0, 7'h00, 7'h00, 7'h00, 3'b001, 3, 1, 7'h00, 7'h00, 7'h00, 0);
    add(0, 7'h00, 7'h00, 7'h00, 3'b010, 0, 1, 7'h00, 7'h00, 7'h00, 0);
    add(0, 7'h00, 7'h00, 7'h00, 3'b010, 1, 1, 7'h00, 7'h00, 7'h00, 0);
    add(1, 7'h7F, 7'h41, 7'h3E, 3'b010, 2, 0, 7'h00, 7'h00, 7'h00, 0);
    add(1, 7'h01, 7'h02, 7'h04, 3'b010, 3, 0, 7'h00, 7'h00, 7'h00, 0);
    add(1, 7'h01, 7'h02, 7'h04, 3'b100, 0, 0, 7'h00, 7'h00, 7'h00, 0);
    add(1, 7'h01, 7'h02, 7'h04, 3'b100, 1, 0, 7'h00, 7'h00, 7'h00, 0);
    add(1, 7'h01, 7'h02, 7'h04, 3'b100, 2, 0, 7'h00, 7'h00, 7'h00, 0);
    add(1, 7'h01, 7'h02, 7'h04, 3'b100, 3, 0, 7'h00, 7'h00, 7'h00, 0);
    add(1, 7'h01, 7'h02, 7'h04, 3'b001, 0, 1, 7'h7F, 7'h41, 7'h3E, 1);
    add(1, 7'h01, 7'h02, 7'h04, 3'b001, 1, 0, 7'h7F, 7'h41, 7'h3E, 0);
    add(0, 7'h00, 7'h00, 7'h00, 3'b001, 2, 0, 7'h7F, 7'h41, 7'h3E, 0);
    add(0, 7'h00, 7'h00, 7'h00, 3'b001, 3, 0, 7'h7F, 7'h41, 7'h3E, 0);
    add(0, 7'h00, 7'h00, 7'h00, 3'b010, 0, 0, 7'h7F, 7'h41, 7'h3E, 0);
    add(0, 7'h00, 7'h00, 7'h00, 3'b010, 1, 0, 7'h7F, 7'h41, 7'h3E, 0);
    add(0, 7'h00, 7'h00, 7'h00, 3'b010, 2, 0, 7'h7F, 7'h41, 7'h3E, 0);
    add(0, 7'h00, 7'h00, 7'h00, 3'b010, 3, 0, 7'h7F, 7'h41, 7'h3E, 0);
    add(0, 7'h00, 7'h00, 7'h00, 3'b100, 0, 0, 7'h7F, 7'h41, 7'h3E, 0);
    add(0, 7'h00, 7'h00, 7'h00, 3'b100, 1, 0, 7'h7F, 7'h41, 7'h3E, 0);
    add(0, 7'h00, 7'h00, 7'h00, 3'b100, 2, 0, 7'h7F, 7'h41, 7'h3E, 0);
    add(0, 7'h00, 7'h00, 7'h00, 3'b100, 3, 0, 7'h7F, 7'h41, 7'h3E, 0);
    add(0, 7'h00, 7'h00, 7'h00, 3'b001, 0, 1, 7'h01, 7'h02, 7'h04, 1);

    // Reset state
    step();
    step();
    chk("reset_ring", ring_counter, gate(3'b001, 0, 1'b1));
    chk("reset_cols", {col_2, col_1, col_0}, 21'h0);
    chk("reset_ready", img_if.img_ready, 1'b1);
    chk("reset_fs", frame_start, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].valid, vecs[i].c2, vecs[i].c1, vecs[i].c0);
      step();
      $display("vec %0d: ring=%b ready=%b cols=%h/%h/%h fs=%b", i, ring_counter,
               img_if.img_ready, col_2, col_1, col_0, frame_start);
      chk($sformatf("vec%0d_ring", i), ring_counter, gate(vecs[i].ring, vecs[i].cnt, 1'b1));
      chk($sformatf("vec%0d_ready", i), img_if.img_ready, vecs[i].ready);
      chk($sformatf("vec%0d_cols", i), {col_2, col_1, col_0}, {vecs[i].e2, vecs[i].e1, vecs[i].e0});
      chk($sformatf("vec%0d_fs", i), frame_start, vecs[i].fs);
    end

    // Transfer on the boundary tick itself: swapped only at the next boundary.
    drive(1'b1, 1'b0, 7'h00, 7'h00, 7'h00);
    repeat (11) step();
    drive(1'b1, 1'b1, 7'h55, 7'h2A, 7'h15);
    step();
    $display("boundary xfer: ready=%b col_2=%h fs=%b", img_if.img_ready, col_2, frame_start);
    chk("bxfer_ready", img_if.img_ready, 1'b0);
    chk("bxfer_cols_kept", {col_2, col_1, col_0}, {7'h01, 7'h02, 7'h04});
    chk("bxfer_fs", frame_start, 1'b1);
    drive(1'b1, 1'b0, 7'h00, 7'h00, 7'h00);
    repeat (11) step();
    chk("bxfer_not_yet", {col_2, col_1, col_0}, {7'h01, 7'h02, 7'h04});
    step();
    $display("boundary xfer swap: cols=%h/%h/%h fs=%b", col_2, col_1, col_0, frame_start);
    chk("bxfer_swapped", {col_2, col_1, col_0}, {7'h55, 7'h2A, 7'h15});
    chk("bxfer_swap_fs", frame_start, 1'b1);
    chk("bxfer_swap_ready", img_if.img_ready, 1'b1);

    // Enable freeze in slot 010 at count 2.
    repeat (6) step();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("freeze%0d_ring", k), ring_counter, 3'b000);
    end
    en = 1'b1;
    #1;
    $display("resume: ring=%b", ring_counter);
    chk("resume_cnt2", ring_counter, gate(3'b010, 2, 1'b1));
    step();
    chk("resume_cnt3", ring_counter, gate(3'b010, 3, 1'b1));
    step();
    chk("resume_next_slot", ring_counter, gate(3'b100, 0, 1'b1));
    step();
    chk("resume_next_slot_c1", ring_counter, gate(3'b100, 1, 1'b1));

    // Mid-frame reset with a transfer offered during reset.
    rst = 1'b1;
    drive(1'b1, 1'b1, 7'h33, 7'h33, 7'h33);
    step();
    $display("mid reset: ring=%b cols=%h/%h/%h ready=%b", ring_counter, col_2, col_1, col_0,
             img_if.img_ready);
    chk("midrst_ring", ring_counter, gate(3'b001, 0, 1'b1));
    chk("midrst_cols", {col_2, col_1, col_0}, 21'h0);
    chk("midrst_ready", img_if.img_ready, 1'b1);
    chk("midrst_fs", frame_start, 1'b0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 7'h00, 7'h00, 7'h00);
    step();
    chk("midrst_ring_c1", ring_counter, gate(3'b001, 1, 1'b1));
    chk("midrst_ready_kept", img_if.img_ready, 1'b1);

    // Randomised traffic against the model.
    for (int k = 0; k < 800; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
            column_t'($urandom), column_t'($urandom), column_t'($urandom));
      step();
      $display("rand %0d: rst=%b en=%b ring=%b ready=%b cols=%h/%h/%h fs=%b", k, rst, en,
               ring_counter, img_if.img_ready, col_2, col_1, col_0, frame_start);
      chk($sformatf("rand%0d_ring", k), ring_counter, model_ring());
      chk($sformatf("rand%0d_ready", k), img_if.img_ready, m_q.size() == 0);
      chk($sformatf("rand%0d_cols", k), {col_2, col_1, col_0}, {m_act[2], m_act[1], m_act[0]});
      chk($sformatf("rand%0d_fs", k), frame_start, m_fs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
